issue_scoreboard: RTL and testbench

//  Issue-stage controller between the decoder output and the ALU/execute stage.
//  - Tracks which architectural registers have a write in flight.
//  - Holds a decoded instruction until its source (RAW) and destination (WAW) registers are free.
//  - Serialises instructions flagged dec_serialize (ll/sc/mtc0): they issue only when nothing is in flight.
//  - Drives the stall back to fetch/decode.

---
 rtl/issue_scoreboard.sv | 127 ++++++++++++
 tb/tb_issue_scoreboard.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard: holds a decoded instruction until its RAW/WAW registers are free,
// serialises flagged instructions through a DRAIN state and tracks in-flight register writes.
module issue_scoreboard #(
    parameter int MAX_INFLIGHT  = 4,
    parameter int WB_BYPASS     = 1,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    input  logic        dec_uses_rs,
    input  logic [4:0]  dec_rs_addr,
    input  logic        dec_uses_rt,
    input  logic [4:0]  dec_rt_addr,
    input  logic        dec_uses_rw,
    input  logic [4:0]  dec_rw_addr,
    input  logic        dec_serialize,
    input  logic        flush,
    input  logic        ex_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rw_addr,
    output logic        issue_valid,
    output logic        dec_stall,
    output logic [3:0]  inflight_cnt,
    output logic [31:0] pending_vec,
    output logic        state_drain,
    output logic        stall_timeout,
    output logic        err_spurious_wb
);

    localparam int          TW      = $clog2(STALL_TIMEOUT + 1);
    localparam logic [3:0]  MAX_CNT = 4'(MAX_INFLIGHT);
    localparam logic [TW-1:0] TO_LAST = TW'(STALL_TIMEOUT - 1);
    localparam logic [TW-1:0] TO_SAT  = TW'(STALL_TIMEOUT);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t        state, state_next;
    logic [31:0]   wb_onehot, rw_onehot, bypass_mask, eff;
    logic          raw, waw, full, go, cnt_zero;
    logic          set_pend, clr_pend, spurious, drain_last_wb;
    logic [31:0]   pend_next;
    logic [TW-1:0] stall_cnt;

    assign wb_onehot   = 32'd1 << wb_rw_addr;
    assign rw_onehot   = 32'd1 << dec_rw_addr;
    assign bypass_mask = ((WB_BYPASS != 0) && wb_valid) ? wb_onehot : 32'd0;
    assign eff         = pending_vec & ~bypass_mask;

    assign raw      = (dec_uses_rs & eff[dec_rs_addr]) | (dec_uses_rt & eff[dec_rt_addr]);
    assign waw      = dec_uses_rw & eff[dec_rw_addr];
    assign full     = (inflight_cnt == MAX_CNT) & ~wb_valid;
    assign cnt_zero = (inflight_cnt == 4'd0);

    assign set_pend = go & dec_uses_rw & (dec_rw_addr != 5'd0);
    assign clr_pend = wb_valid & (wb_rw_addr != 5'd0) & pending_vec[wb_rw_addr];
    assign spurious = wb_valid & (wb_rw_addr != 5'd0) & ~pending_vec[wb_rw_addr]
                      & ~(set_pend & (dec_rw_addr == wb_rw_addr));
    assign drain_last_wb = (WB_BYPASS != 0) & clr_pend & (inflight_cnt == 4'd1);

    // Outputs are forced low while reset is asserted, even with a live decoder input.
    always_comb begin
        state_next = state;
        go         = 1'b0;
        case (state)
            RUN: begin
                go = rst_n & dec_valid & ~flush & ex_ready & ~raw & ~waw & ~full
                     & (~dec_serialize | cnt_zero);
                if (dec_valid & ~flush & dec_serialize & ~cnt_zero)
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (flush | cnt_zero | drain_last_wb)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    assign issue_valid = go;
    assign dec_stall   = rst_n & dec_valid & ~flush & ~go;
    assign state_drain = (state == DRAIN);

    // A set and a clear of the same register in one cycle leaves it pending.
    always_comb begin
        pend_next = pending_vec;
        if (clr_pend)
            pend_next = pend_next & ~wb_onehot;
        if (set_pend)
            pend_next = pend_next | rw_onehot;
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            pending_vec     <= 32'd0;
            inflight_cnt    <= 4'd0;
            err_spurious_wb <= 1'b0;
        end else begin
            state       <= state_next;
            pending_vec <= pend_next;
            if (set_pend & ~clr_pend & (inflight_cnt != MAX_CNT))
                inflight_cnt <= inflight_cnt + 4'd1;
            else if (clr_pend & ~set_pend & ~cnt_zero)
                inflight_cnt <= inflight_cnt - 4'd1;
            if (spurious)
                err_spurious_wb <= 1'b1;
        end
    end

    // Counts consecutive stalled cycles; the flag stays set once the limit is hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else if (dec_stall) begin
            if (stall_cnt != TO_SAT)
                stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt >= TO_LAST)
                stall_timeout <= 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: a bypassing instance (main) and a non-bypassing one
// (used for the writeback-latency case), both with MAX_INFLIGHT=4 and a short stall timeout.
module tb_issue_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid, dec_uses_rs, dec_uses_rt, dec_uses_rw, dec_serialize;
    logic [4:0]  dec_rs_addr, dec_rt_addr, dec_rw_addr, wb_rw_addr;
    logic        flush, ex_ready, wb_valid;

    logic        issue_valid, dec_stall, state_drain, stall_timeout, err_spurious_wb;
    logic [3:0]  inflight_cnt;
    logic [31:0] pending_vec;
    logic        issue_valid_b, dec_stall_b, state_drain_b, stall_timeout_b, err_spurious_wb_b;
    logic [3:0]  inflight_cnt_b;
    logic [31:0] pending_vec_b;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    issue_scoreboard #(.MAX_INFLIGHT(4), .WB_BYPASS(1), .STALL_TIMEOUT(16)) u_byp (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_uses_rs(dec_uses_rs), .dec_rs_addr(dec_rs_addr),
        .dec_uses_rt(dec_uses_rt), .dec_rt_addr(dec_rt_addr),
        .dec_uses_rw(dec_uses_rw), .dec_rw_addr(dec_rw_addr),
        .dec_serialize(dec_serialize), .flush(flush), .ex_ready(ex_ready),
        .wb_valid(wb_valid), .wb_rw_addr(wb_rw_addr),
        .issue_valid(issue_valid), .dec_stall(dec_stall), .inflight_cnt(inflight_cnt),
        .pending_vec(pending_vec), .state_drain(state_drain),
        .stall_timeout(stall_timeout), .err_spurious_wb(err_spurious_wb)
    );

    issue_scoreboard #(.MAX_INFLIGHT(4), .WB_BYPASS(0), .STALL_TIMEOUT(16)) u_nobyp (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_uses_rs(dec_uses_rs), .dec_rs_addr(dec_rs_addr),
        .dec_uses_rt(dec_uses_rt), .dec_rt_addr(dec_rt_addr),
        .dec_uses_rw(dec_uses_rw), .dec_rw_addr(dec_rw_addr),
        .dec_serialize(dec_serialize), .flush(flush), .ex_ready(ex_ready),
        .wb_valid(wb_valid), .wb_rw_addr(wb_rw_addr),
        .issue_valid(issue_valid_b), .dec_stall(dec_stall_b), .inflight_cnt(inflight_cnt_b),
        .pending_vec(pending_vec_b), .state_drain(state_drain_b),
        .stall_timeout(stall_timeout_b), .err_spurious_wb(err_spurious_wb_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setIdle();
        dec_valid = 0; dec_uses_rs = 0; dec_rs_addr = 0; dec_uses_rt = 0; dec_rt_addr = 0;
        dec_uses_rw = 0; dec_rw_addr = 0; dec_serialize = 0; flush = 0; ex_ready = 0;
        wb_valid = 0; wb_rw_addr = 0;
    endtask

    // Drive one cycle of inputs just after the falling edge; combinational outputs settle by #1.
    task automatic applyStimulus(input logic v, input logic urs, input logic [4:0] rs,
                                 input logic urt, input logic [4:0] rt,
                                 input logic urw, input logic [4:0] rw,
                                 input logic ser, input logic fl, input logic exr,
                                 input logic wbv, input logic [4:0] wba);
        @(negedge clk);
        dec_valid = v; dec_uses_rs = urs; dec_rs_addr = rs; dec_uses_rt = urt;
        dec_rt_addr = rt; dec_uses_rw = urw; dec_rw_addr = rw; dec_serialize = ser;
        flush = fl; ex_ready = exr; wb_valid = wbv; wb_rw_addr = wba;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        setIdle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        setIdle();
        rst_n = 1'b0;
        #12;
        checkOutput("reset_issue", {31'd0, issue_valid}, 32'd0);
        checkOutput("reset_stall", {31'd0, dec_stall}, 32'd0);
        checkOutput("reset_cnt", {28'd0, inflight_cnt}, 32'd0);
        checkOutput("reset_pending", pending_vec, 32'd0);
        checkOutput("reset_drain", {31'd0, state_drain}, 32'd0);
        checkOutput("reset_timeout", {31'd0, stall_timeout}, 32'd0);
        checkOutput("reset_err", {31'd0, err_spurious_wb}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // RAW on r5, released by its writeback (bypass: same cycle, no bypass: next cycle)
        applyStimulus(1, 1, 1, 1, 2, 1, 5, 0, 0, 1, 0, 0);
        checkOutput("t1_issue_r5", {31'd0, issue_valid}, 32'd1);
        checkOutput("t1_issue_r5_nb", {31'd0, issue_valid_b}, 32'd1);
        tick();
        checkOutput("t1_pending_r5", pending_vec, 32'h0000_0020);
        applyStimulus(1, 1, 5, 1, 1, 1, 6, 0, 0, 1, 0, 0);
        checkOutput("t1_raw_issue", {31'd0, issue_valid}, 32'd0);
        checkOutput("t1_raw_stall", {31'd0, dec_stall}, 32'd1);
        checkOutput("t1_raw_stall_nb", {31'd0, dec_stall_b}, 32'd1);
        applyStimulus(1, 1, 5, 1, 1, 1, 6, 0, 0, 1, 1, 5);
        checkOutput("t1_byp_issue", {31'd0, issue_valid}, 32'd1);
        checkOutput("t1_byp_stall", {31'd0, dec_stall}, 32'd0);
        checkOutput("t1_nb_issue_wbcycle", {31'd0, issue_valid_b}, 32'd0);
        checkOutput("t1_nb_stall_wbcycle", {31'd0, dec_stall_b}, 32'd1);
        tick();
        checkOutput("t1_pending_r6", pending_vec, 32'h0000_0040);
        checkOutput("t1_cnt", {28'd0, inflight_cnt}, 32'd1);
        checkOutput("t1_nb_pending", pending_vec_b, 32'd0);
        applyStimulus(1, 1, 5, 1, 1, 1, 6, 0, 0, 1, 0, 0);
        checkOutput("t1_nb_issue_next", {31'd0, issue_valid_b}, 32'd1);
        doReset();

        // Scoreboard full at MAX_INFLIGHT, a writeback frees a slot in the same cycle
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 1, 5'(i), 0, 0, 1, 0, 0);
            checkOutput($sformatf("t2_issue_r%0d", i), {31'd0, issue_valid}, 32'd1);
            tick();
        end
        applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0, 1, 0, 0);
        checkOutput("t2_full_stall", {31'd0, dec_stall}, 32'd1);
        checkOutput("t2_full_issue", {31'd0, issue_valid}, 32'd0);
        checkOutput("t2_full_cnt", {28'd0, inflight_cnt}, 32'd4);
        applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0, 1, 1, 1);
        checkOutput("t2_wb_issue", {31'd0, issue_valid}, 32'd1);
        tick();
        checkOutput("t2_cnt_after", {28'd0, inflight_cnt}, 32'd4);
        checkOutput("t2_pending_after", pending_vec, 32'h0000_009C);
        doReset();

        // Serialising sc waits in DRAIN for the r8 writeback
        applyStimulus(1, 0, 0, 0, 0, 1, 8, 0, 0, 1, 0, 0);
        tick();
        applyStimulus(1, 1, 3, 1, 4, 1, 4, 1, 0, 1, 0, 0);
        checkOutput("t3_sc_no_issue", {31'd0, issue_valid}, 32'd0);
        checkOutput("t3_sc_stall", {31'd0, dec_stall}, 32'd1);
        tick();
        checkOutput("t3_drain", {31'd0, state_drain}, 32'd1);
        applyStimulus(1, 1, 3, 1, 4, 1, 4, 1, 0, 1, 1, 8);
        checkOutput("t3_drain_no_issue", {31'd0, issue_valid}, 32'd0);
        tick();
        checkOutput("t3_back_run", {31'd0, state_drain}, 32'd0);
        checkOutput("t3_cnt_zero", {28'd0, inflight_cnt}, 32'd0);
        applyStimulus(1, 1, 3, 1, 4, 1, 4, 1, 0, 1, 0, 0);
        checkOutput("t3_sc_issue", {31'd0, issue_valid}, 32'd1);
        tick();
        checkOutput("t3_sc_pending", pending_vec, 32'h0000_0010);
        doReset();

        // Writes to r0 are ignored; a writeback to a non-pending register is sticky-flagged
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        checkOutput("t4_r0_issue", {31'd0, issue_valid}, 32'd1);
        tick();
        checkOutput("t4_r0_pending", pending_vec, 32'd0);
        checkOutput("t4_r0_cnt", {28'd0, inflight_cnt}, 32'd0);
        checkOutput("t4_no_err_yet", {31'd0, err_spurious_wb}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        tick();
        checkOutput("t4_err_set", {31'd0, err_spurious_wb}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t4_err_sticky", {31'd0, err_spurious_wb}, 32'd1);
        doReset();

        // Stall timeout after 16 consecutive stalled cycles, then flush
        applyStimulus(1, 0, 0, 0, 0, 1, 10, 0, 0, 1, 0, 0);
        tick();
        applyStimulus(1, 1, 10, 0, 0, 1, 11, 0, 0, 1, 0, 0);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("t5_timeout_early", {31'd0, stall_timeout}, 32'd0);
        checkOutput("t5_still_stalled", {31'd0, dec_stall}, 32'd1);
        tick();
        checkOutput("t5_timeout_set", {31'd0, stall_timeout}, 32'd1);
        applyStimulus(1, 1, 10, 0, 0, 1, 11, 0, 1, 1, 0, 0);
        checkOutput("t5_flush_stall", {31'd0, dec_stall}, 32'd0);
        checkOutput("t5_flush_issue", {31'd0, issue_valid}, 32'd0);
        tick();
        checkOutput("t5_flush_pending", pending_vec, 32'h0000_0400);
        checkOutput("t5_timeout_sticky", {31'd0, stall_timeout}, 32'd1);
        doReset();

        // Asynchronous reset while in DRAIN with three writes outstanding
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 1, 5'(i), 0, 0, 1, 0, 0);
            tick();
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        tick();
        checkOutput("t6_drain", {31'd0, state_drain}, 32'd1);
        checkOutput("t6_cnt3", {28'd0, inflight_cnt}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_drain", {31'd0, state_drain}, 32'd0);
        checkOutput("t6_rst_cnt", {28'd0, inflight_cnt}, 32'd0);
        checkOutput("t6_rst_pending", pending_vec, 32'd0);
        checkOutput("t6_rst_issue", {31'd0, issue_valid}, 32'd0);
        checkOutput("t6_rst_stall", {31'd0, dec_stall}, 32'd0);
        @(negedge clk);
        setIdle();
        rst_n = 1'b1;
        tick();
        checkOutput("t6_run_after", {31'd0, state_drain}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
